// File: rtl/exe_stage_unit.sv
// -----------------------------------------------------------------------------
// exe_stage_unit
//
// Purpose:
//   Execute stage of the pipeline. Consumes the ID/EX register outputs, runs
//   single-cycle ALU operations, resolves branches for the IF stage and drives
//   the registered EX/MEM-side outputs. MUL and DIV run on an iterative
//   shift/add (MUL) and restoring-division (DIV) engine that takes DATA_W
//   iterations. While the engine is busy, stall holds the upstream stages.
//
// Build option:
//   EXE_MULDIV_EN - when defined, the IDLE/BUSY/DONE FSM and the iterative
//                   engine are built. When undefined, stall is tied 0 and
//                   MUL/DIV behave like undefined codes: result 0, single
//                   cycle, controls passed through.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   Val1, Val2    operands (Val2 also carries the sign-extended branch offset)
//   Reg2          store data / BNE compare value
//   PC_in         PC of the instruction in EX
//   Br_type       00 none, 01 BEZ, 10 BNE, 11 JMP
//   EXE_CMD       operation code
//   Dest_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in   pipeline controls
//   stall         freeze PC, IF/ID and ID/EX while the engine is busy
//   Br_taken      combinational branch decision (forced 0 while stalled)
//   Br_addr       combinational branch target PC_in + (Val2 << 2)
//   ALU_result, Reg2_out, Dest, MEM_R_EN, MEM_W_EN, WB_EN   registered outputs
// -----------------------------------------------------------------------------
module exe_stage_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Val1,
   input  logic [DATA_W-1:0] Val2,
   input  logic [DATA_W-1:0] Reg2,
   input  logic [31:0]       PC_in,
   input  logic [1:0]        Br_type,
   input  logic [3:0]        EXE_CMD,
   input  logic [4:0]        Dest_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              WB_EN_in,
   output logic              stall,
   output logic              Br_taken,
   output logic [31:0]       Br_addr,
   output logic [DATA_W-1:0] ALU_result,
   output logic [DATA_W-1:0] Reg2_out,
   output logic [4:0]        Dest,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              WB_EN
);

   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0100;
   localparam logic [3:0] CMD_OR  = 4'b0101;
   localparam logic [3:0] CMD_NOR = 4'b0110;
   localparam logic [3:0] CMD_XOR = 4'b0111;
   localparam logic [3:0] CMD_SLL = 4'b1000;
   localparam logic [3:0] CMD_SRL = 4'b1001;
   localparam logic [3:0] CMD_SRA = 4'b1010;

   localparam logic [1:0] BR_BEZ = 2'b01;
   localparam logic [1:0] BR_BNE = 2'b10;
   localparam logic [1:0] BR_JMP = 2'b11;

   logic [DATA_W-1:0] w_aluResult;
   logic [DATA_W-1:0] w_resultIn;
   logic              w_capture;
   logic              w_stall;
   logic              w_brCond;
   logic [31:0]       w_brOffset;

   // Single-cycle ALU. MUL/DIV codes fall into the default here; when the
   // engine is built its result is selected separately in the DONE state.
   always_comb begin
      w_aluResult = '0;
      case (EXE_CMD)
         CMD_ADD: w_aluResult = Val1 + Val2;
         CMD_SUB: w_aluResult = Val1 - Val2;
         CMD_AND: w_aluResult = Val1 & Val2;
         CMD_OR:  w_aluResult = Val1 | Val2;
         CMD_NOR: w_aluResult = ~(Val1 | Val2);
         CMD_XOR: w_aluResult = Val1 ^ Val2;
         CMD_SLL: w_aluResult = Val1 << Val2[4:0];
         CMD_SRL: w_aluResult = Val1 >> Val2[4:0];
         CMD_SRA: w_aluResult = $signed(Val1) >>> Val2[4:0];
         default: w_aluResult = '0;
      endcase
   end

   // Branch resolution. A stalled instruction must not redirect fetch, since
   // the instruction sitting in EX has not actually completed yet.
   always_comb begin
      w_brCond = 1'b0;
      case (Br_type)
         BR_BEZ:  w_brCond = (Val1 == '0);
         BR_BNE:  w_brCond = (Val1 != Reg2);
         BR_JMP:  w_brCond = 1'b1;
         default: w_brCond = 1'b0;
      endcase
   end

   assign w_brOffset = 32'(Val2 << 2);
   assign Br_addr    = PC_in + w_brOffset;
   assign Br_taken   = w_brCond & ~w_stall;
   assign stall      = w_stall;

`ifdef EXE_MULDIV_EN
   localparam logic [3:0] CMD_MUL = 4'b1100;
   localparam logic [3:0] CMD_DIV = 4'b1101;
   localparam int         CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_count;
   logic              r_isDiv;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_opA;
   logic [DATA_W-1:0] r_opB;
   logic              w_isMulDiv;
   logic [DATA_W-1:0] w_mulAcc;
   logic [DATA_W:0]   w_remShift;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W-1:0] w_engineResult;

   assign w_isMulDiv = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. DONE always returns to IDLE even though upstream still
   // shows the same MUL/DIV, so that instruction does not restart; the
   // following instruction arrives in IDLE with no gap.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_isMulDiv) w_nextState = BUSY;
         BUSY:    if (r_count == LAST_ITER) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // FSM outputs: stall request and what the output register loads.
   // Anything not captured is loaded as a bubble.
   always_comb begin
      w_stall    = 1'b0;
      w_capture  = 1'b0;
      w_resultIn = w_aluResult;
      case (r_state)
         IDLE: begin
            w_stall   = w_isMulDiv;
            w_capture = ~w_isMulDiv;
         end
         BUSY: begin
            w_stall = 1'b1;
         end
         DONE: begin
            w_capture  = 1'b1;
            w_resultIn = w_engineResult;
         end
         default: begin
            w_stall = 1'b0;
         end
      endcase
   end

   // One engine iteration. MUL adds the shifted multiplicand when the current
   // multiplier bit is set. DIV shifts the next dividend bit into the partial
   // remainder and keeps the trial subtraction when it does not go negative.
   // A zero divisor never goes negative, so every quotient bit becomes 1.
   assign w_mulAcc       = r_opA[0] ? (r_acc + r_opB) : r_acc;
   assign w_remShift     = {r_acc, r_opA[DATA_W-1]};
   assign w_trial        = w_remShift - {1'b0, r_opB};
   assign w_engineResult = r_isDiv ? r_opA : r_acc;

   // Engine datapath. For MUL, r_opA is the multiplier (shifted right) and
   // r_opB the multiplicand (shifted left). For DIV, r_opA holds the dividend
   // and fills with quotient bits from the right, r_opB is the divisor and
   // r_acc the partial remainder.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_isDiv <= 1'b0;
         r_acc   <= '0;
         r_opA   <= '0;
         r_opB   <= '0;
      end else if (r_state == IDLE && w_isMulDiv) begin
         r_count <= '0;
         r_isDiv <= (EXE_CMD == CMD_DIV);
         r_acc   <= '0;
         r_opA   <= (EXE_CMD == CMD_DIV) ? Val1 : Val2;
         r_opB   <= (EXE_CMD == CMD_DIV) ? Val2 : Val1;
      end else if (r_state == BUSY) begin
         r_count <= r_count + 1'b1;
         if (r_isDiv) begin
            if (!w_trial[DATA_W]) begin
               r_acc <= w_trial[DATA_W-1:0];
               r_opA <= {r_opA[DATA_W-2:0], 1'b1};
            end else begin
               r_acc <= w_remShift[DATA_W-1:0];
               r_opA <= {r_opA[DATA_W-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_mulAcc;
            r_opA <= r_opA >> 1;
            r_opB <= r_opB << 1;
         end
      end
   end
`else
   // Without the engine every instruction completes in a single cycle.
   always_comb begin
      w_stall    = 1'b0;
      w_capture  = 1'b1;
      w_resultIn = w_aluResult;
   end
`endif

   // EX/MEM output register: either captures the finishing instruction or
   // loads a bubble so nothing downstream acts on a stalled instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALU_result <= '0;
         Reg2_out   <= '0;
         Dest       <= '0;
         MEM_R_EN   <= 1'b0;
         MEM_W_EN   <= 1'b0;
         WB_EN      <= 1'b0;
      end else if (w_capture) begin
         ALU_result <= w_resultIn;
         Reg2_out   <= Reg2;
         Dest       <= Dest_in;
         MEM_R_EN   <= MEM_R_EN_in;
         MEM_W_EN   <= MEM_W_EN_in;
         WB_EN      <= WB_EN_in;
      end else begin
         ALU_result <= '0;
         Reg2_out   <= '0;
         Dest       <= '0;
         MEM_R_EN   <= 1'b0;
         MEM_W_EN   <= 1'b0;
         WB_EN      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_unit
//
// Directed self-checking bench for exe_stage_unit. Expected values are
// hand-computed constants. Behaviour of MUL/DIV follows the EXE_MULDIV_EN
// build option, matching whatever the design was compiled with.
// -----------------------------------------------------------------------------
module tb_exe_stage_unit;

   logic        clk;
   logic        rst;
   logic [31:0] Val1;
   logic [31:0] Val2;
   logic [31:0] Reg2;
   logic [31:0] PC_in;
   logic [1:0]  Br_type;
   logic [3:0]  EXE_CMD;
   logic [4:0]  Dest_in;
   logic        MEM_R_EN_in;
   logic        MEM_W_EN_in;
   logic        WB_EN_in;
   logic        stall;
   logic        Br_taken;
   logic [31:0] Br_addr;
   logic [31:0] ALU_result;
   logic [31:0] Reg2_out;
   logic [4:0]  Dest;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic        WB_EN;

   int checks;
   int failures;

   exe_stage_unit #(.DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .Val1        (Val1),
      .Val2        (Val2),
      .Reg2        (Reg2),
      .PC_in       (PC_in),
      .Br_type     (Br_type),
      .EXE_CMD     (EXE_CMD),
      .Dest_in     (Dest_in),
      .MEM_R_EN_in (MEM_R_EN_in),
      .MEM_W_EN_in (MEM_W_EN_in),
      .WB_EN_in    (WB_EN_in),
      .stall       (stall),
      .Br_taken    (Br_taken),
      .Br_addr     (Br_addr),
      .ALU_result  (ALU_result),
      .Reg2_out    (Reg2_out),
      .Dest        (Dest),
      .MEM_R_EN    (MEM_R_EN),
      .MEM_W_EN    (MEM_W_EN),
      .WB_EN       (WB_EN)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction onto the ID/EX-side inputs.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [31:0] r2,
                                input logic [31:0] pc, input logic [1:0] br,
                                input logic [4:0] dst, input logic mr,
                                input logic mw, input logic wb);
      EXE_CMD     = cmd;
      Val1        = v1;
      Val2        = v2;
      Reg2        = r2;
      PC_in       = pc;
      Br_type     = br;
      Dest_in     = dst;
      MEM_R_EN_in = mr;
      MEM_W_EN_in = mw;
      WB_EN_in    = wb;
   endtask

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Run one MUL/DIV from first presentation through its result edge.
   task automatic runLong(input string tag, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input logic [31:0] expected);
      int stallCycles;
      applyStimulus(cmd, a, b, 32'h0, 32'h0, 2'b11, dst, 1'b0, 1'b0, 1'b1);
      #1;
`ifdef EXE_MULDIV_EN
      checkOutput({tag, " stall_same_cycle"}, 32'(stall), 32'd1);
      checkOutput({tag, " br_forced_off"}, 32'(Br_taken), 32'd0);
      stallCycles = 0;
      while (stall && stallCycles < 40) begin
         stallCycles++;
         tick();
         // Scramble operands mid-operation; the engine must use latched ones.
         if (stallCycles == 5) begin
            Val1 = 32'hA5A5_1234;
            Val2 = 32'h0000_0003;
         end
         if (stall) begin
            checkOutput({tag, " bubble_wb"}, 32'(WB_EN), 32'd0);
            checkOutput({tag, " bubble_result"}, ALU_result, 32'd0);
         end
      end
      checkOutput({tag, " stall_cycles"}, 32'(stallCycles), 32'd33);
      checkOutput({tag, " done_wb_pending"}, 32'(WB_EN), 32'd0);
      tick();
      checkOutput({tag, " result"}, ALU_result, expected);
      checkOutput({tag, " wb"}, 32'(WB_EN), 32'd1);
      checkOutput({tag, " dest"}, 32'(Dest), 32'(dst));
`else
      checkOutput({tag, " no_stall"}, 32'(stall), 32'd0);
      tick();
      checkOutput({tag, " result_zero"}, ALU_result, 32'd0);
      checkOutput({tag, " wb"}, 32'(WB_EN), 32'd1);
      checkOutput({tag, " dest"}, 32'(Dest), 32'(dst));
      if (expected == 32'hFFFF_FFFF) begin
         checkOutput({tag, " stall_after"}, 32'(stall), 32'd0);
      end
`endif
   endtask

   // Directed sequence.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 2'b00, 5'd3, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("reset_result", ALU_result, 32'd0);
      checkOutput("reset_wb", 32'(WB_EN), 32'd0);
      checkOutput("reset_dest", 32'(Dest), 32'd0);
      checkOutput("reset_stall", 32'(stall), 32'd0);

      // ADD 5+7
      rst = 1'b0;
      #1;
      checkOutput("add_stall", 32'(stall), 32'd0);
      tick();
      checkOutput("add_result", ALU_result, 32'd12);
      checkOutput("add_wb", 32'(WB_EN), 32'd1);
      checkOutput("add_dest", 32'(Dest), 32'd3);

      // Single-cycle ALU patterns
      applyStimulus(4'b1010, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 2'b00, 5'd4, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("sra", ALU_result, 32'hF800_0000);
      applyStimulus(4'b0010, 32'd3, 32'd5, 32'h0, 32'h0, 2'b00, 5'd5, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("sub", ALU_result, 32'hFFFF_FFFE);
      applyStimulus(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("and", ALU_result, 32'h0000_F000);
      applyStimulus(4'b0101, 32'h0000_00F0, 32'h0000_000F, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("or", ALU_result, 32'h0000_00FF);
      applyStimulus(4'b0110, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("nor", ALU_result, 32'hFFFF_FFFF);
      applyStimulus(4'b0111, 32'h0000_00FF, 32'h0000_000F, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("xor", ALU_result, 32'h0000_00F0);
      applyStimulus(4'b1000, 32'd1, 32'h0000_0021, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("sll_low5", ALU_result, 32'd2);
      applyStimulus(4'b1001, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("srl", ALU_result, 32'h0800_0000);
      applyStimulus(4'b0011, 32'd9, 32'd9, 32'h0, 32'h0, 2'b00, 5'd7, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("undef_code", ALU_result, 32'd0);
      checkOutput("undef_dest", 32'(Dest), 32'd7);

      // Store: address via ADD, store data passed to Reg2_out
      applyStimulus(4'b0000, 32'h100, 32'h4, 32'hDEAD_BEEF, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("store_addr", ALU_result, 32'h104);
      checkOutput("store_data", Reg2_out, 32'hDEAD_BEEF);
      checkOutput("store_wen", 32'(MEM_W_EN), 32'd1);
      checkOutput("store_wb", 32'(WB_EN), 32'd0);
      applyStimulus(4'b0000, 32'h200, 32'h8, 32'h0, 32'h0, 2'b00, 5'd8, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("load_ren", 32'(MEM_R_EN), 32'd1);
      checkOutput("load_wen", 32'(MEM_W_EN), 32'd0);

      // Branches (combinational)
      applyStimulus(4'b0000, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'h40, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("bne_taken", 32'(Br_taken), 32'd1);
      checkOutput("bne_addr", Br_addr, 32'h3C);
      applyStimulus(4'b0000, 32'd2, 32'h1, 32'd2, 32'h40, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("bne_equal", 32'(Br_taken), 32'd0);
      applyStimulus(4'b0000, 32'd1, 32'h1, 32'd0, 32'h40, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("bez_nonzero", 32'(Br_taken), 32'd0);
      applyStimulus(4'b0000, 32'd0, 32'h1, 32'd0, 32'h40, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("bez_zero", 32'(Br_taken), 32'd1);
      checkOutput("bez_addr", Br_addr, 32'h44);
      applyStimulus(4'b0000, 32'd7, 32'h4, 32'd0, 32'h100, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("jmp_taken", 32'(Br_taken), 32'd1);
      checkOutput("jmp_addr", Br_addr, 32'h110);
      applyStimulus(4'b0000, 32'd7, 32'h4, 32'd0, 32'h100, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("no_branch", 32'(Br_taken), 32'd0);
      tick();

      // MUL/DIV
      runLong("mul_6x7", 4'b1100, 32'd6, 32'd7, 5'd10, 32'd42);
      applyStimulus(4'b0000, 32'd20, 32'd22, 32'h0, 32'h0, 2'b00, 5'd11, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("add_after_mul_stall", 32'(stall), 32'd0);
      tick();
      checkOutput("add_after_mul", ALU_result, 32'd42);
      checkOutput("add_after_mul_dest", 32'(Dest), 32'd11);

      runLong("div_100_7", 4'b1101, 32'd100, 32'd7, 5'd12, 32'd14);
      runLong("div_by_0", 4'b1101, 32'd55, 32'd0, 5'd13, 32'hFFFF_FFFF);
      runLong("b2b_div", 4'b1101, 32'hFFFF_FFFF, 32'h10, 5'd14, 32'h0FFF_FFFF);
      runLong("b2b_mul", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd1);

      // Reset in the middle of a MUL
      applyStimulus(4'b1100, 32'd6, 32'd7, 32'h0, 32'h0, 2'b00, 5'd9, 1'b0, 1'b0, 1'b1);
      repeat (10) tick();
      rst = 1'b1;
      applyStimulus(4'b0000, 32'd0, 32'd0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("abort_result", ALU_result, 32'd0);
      checkOutput("abort_wb", 32'(WB_EN), 32'd0);
      checkOutput("abort_dest", 32'(Dest), 32'd0);
      checkOutput("abort_reg2", Reg2_out, 32'd0);
      checkOutput("abort_stall", 32'(stall), 32'd0);
      repeat (40) tick();
      checkOutput("abort_never_wb", 32'(WB_EN), 32'd0);
      checkOutput("abort_never_dest", 32'(Dest), 32'd0);
      checkOutput("abort_never_stall", 32'(stall), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
